// File: rtl/dot_product_pkg.sv
// Shared widths and controller state encoding for the sequential dot-product engine.
package dot_product_pkg;

   localparam int DP_DATA_W = 7;
   localparam int DP_ACC_W  = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLR    = 3'd1,
      LOAD_A = 3'd2,
      LOAD_B = 3'd3,
      MAC    = 3'd4,
      DONE   = 3'd5
   } dp_state_t;

endpackage

// File: rtl/dot_controlpath.sv
// Moore controller sequencing CLR, then LOAD_A/LOAD_B/MAC per element pair, until stop.
module dot_controlpath
   import dot_product_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic stop,
   output logic lda,
   output logic ldb,
   output logic ldp,
   output logic clrp,
   output logic done
);

   dp_state_t state_q, state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      lda     = 1'b0;
      ldb     = 1'b0;
      ldp     = 1'b0;
      clrp    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE:   if (start) state_d = CLR;
         CLR: begin
            clrp    = 1'b1;
            state_d = LOAD_A;
         end
         LOAD_A: begin
            lda     = 1'b1;
            state_d = LOAD_B;
         end
         LOAD_B: begin
            ldb     = 1'b1;
            state_d = MAC;
         end
         // The pair accumulated in the cycle that sees stop is kept.
         MAC: begin
            ldp     = 1'b1;
            state_d = stop ? DONE : LOAD_A;
         end
         DONE: begin
            done = 1'b1;
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/dot_datapath.sv
// Operand registers A/B and the multiply-accumulate register P.
module dot_datapath
   import dot_product_pkg::*;
#(
   parameter int DATA_W = DP_DATA_W,
   parameter int ACC_W  = DP_ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              lda,
   input  logic              ldb,
   input  logic              ldp,
   input  logic              clrp,
   output logic [ACC_W-1:0]  p_out
);

   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [ACC_W-1:0]    p_q, p_d;
   logic [2*DATA_W-1:0] prod;

   always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      p_d  = p_q;
      prod = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
      if (lda) a_d = data_in;
      if (ldb) b_d = data_in;
      // Clear wins if both are ever raised together; the sum wraps naturally.
      if (clrp)     p_d = '0;
      else if (ldp) p_d = p_q + ACC_W'(prod);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         p_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         p_q <= p_d;
      end
   end

   assign p_out = p_q;

endmodule

// File: rtl/dot_product_unit.sv
// Top level: wires the dot-product controller to its datapath.
module dot_product_unit
   import dot_product_pkg::*;
#(
   parameter int DATA_W = DP_DATA_W,
   parameter int ACC_W  = DP_ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [DATA_W-1:0] data_in,
   output logic [ACC_W-1:0]  p_out,
   output logic              done
);

   logic lda, ldb, ldp, clrp;

   dot_controlpath u_ctrl (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .stop  (stop),
      .lda   (lda),
      .ldb   (ldb),
      .ldp   (ldp),
      .clrp  (clrp),
      .done  (done)
   );

   dot_datapath #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_dp (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_in (data_in),
      .lda     (lda),
      .ldb     (ldb),
      .ldp     (ldp),
      .clrp    (clrp),
      .p_out   (p_out)
   );

endmodule

// File: tb/tb_dot_product_unit.sv
// Scoreboard bench: runs are summed arithmetically when issued; a monitor checks p_out when done rises.
module tb_dot_product_unit;

   localparam int DATA_W = 7;
   localparam int ACC_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic [ACC_W-1:0]  p_out;
   logic              done;

   int total = 0;
   int bad   = 0;

   int exp_q[$];
   int pa[$];
   int pb[$];
   bit lb_stop[$];
   int last_exp = 0;
   bit sim_over = 1'b0;

   always #5 clk = ~clk;

   dot_product_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .stop    (stop),
      .data_in (data_in),
      .p_out   (p_out),
      .done    (done)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Monitor: every rising edge of done must present the next expected sum.
   bit done_prev = 1'b0;
   always @(negedge clk) begin
      if (!sim_over && done === 1'b1 && !done_prev) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got p_out=%0d expected no result", p_out);
         end else begin
            check("scoreboard_p_out", int'(p_out), exp_q.pop_front());
         end
      end
      done_prev = (done === 1'b1);
   end

   // Issues the pairs in pa/pb; abort_after>0 pulses reset after that many pairs.
   task automatic do_run(input int abort_after, input int hold_cycles);
      int n = pa.size();
      int sum = 0;
      for (int i = 0; i < n; i++) sum = (sum + pa[i] * pb[i]) % 65536;
      if (abort_after == 0) exp_q.push_back(sum);
      @(negedge clk) start = 1'b1;                      // IDLE, start sampled
      @(negedge clk) start = 1'($urandom_range(0, 1));  // in CLR
      for (int i = 0; i < n; i++) begin
         @(negedge clk);                                // LOAD_A
         data_in = DATA_W'(pa[i]);
         stop    = 1'b0;
         @(negedge clk);                                // LOAD_B
         data_in = DATA_W'(pb[i]);
         stop    = lb_stop[i];
         start   = 1'($urandom_range(0, 1));
         @(negedge clk);                                // MAC
         data_in = DATA_W'($urandom);
         stop    = (i == n - 1);
         if (i == n - 1) check("done_not_early", int'(done), 0);
         if (abort_after != 0 && i == abort_after - 1) begin
            @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("async_rst_p_out", int'(p_out), 0);
            check("async_rst_done", int'(done), 0);
            start = 1'b0;
            stop  = 1'b0;
            @(negedge clk) rst_n = 1'b1;
            return;
         end
      end
      @(negedge clk);                                   // DONE entered
      stop = 1'b0;
      check("done_after_last_mac", int'(done), 1);
      last_exp = sum;
      start = 1'b1;
      for (int k = 0; k < hold_cycles; k++) begin
         @(negedge clk);
         check("done_held_by_start", int'(done), 1);
      end
      start = 1'b0;
      @(negedge clk);
      check("done_cleared", int'(done), 0);
      repeat (2) @(negedge clk);
      check("p_out_held_in_idle", int'(p_out), last_exp);
   endtask

   task automatic load_pairs(input int n, input int fixed_a, input int fixed_b);
      pa.delete(); pb.delete(); lb_stop.delete();
      for (int i = 0; i < n; i++) begin
         pa.push_back(fixed_a < 0 ? int'($urandom_range(0, 127)) : fixed_a);
         pb.push_back(fixed_b < 0 ? int'($urandom_range(0, 127)) : fixed_b);
         lb_stop.push_back(1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ta[10] = '{2, 4, 1, 1, 4, 2, 1, 2, 8, 1};
      int tb[10] = '{2, 6, 6, 3, 4, 5, 4, 3, 4, 2};

      // Reset with arbitrary inputs, then idle without start.
      start = 1'b1; stop = 1'b1; data_in = 7'h55;
      repeat (3) @(negedge clk);
      check("reset_p_out", int'(p_out), 0);
      check("reset_done", int'(done), 0);
      start = 1'b0; stop = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_no_start_done", int'(done), 0);
      check("idle_no_start_p_out", int'(p_out), 0);

      // Directed ten-pair run (sum 107).
      pa.delete(); pb.delete(); lb_stop.delete();
      for (int i = 0; i < 10; i++) begin
         pa.push_back(ta[i]); pb.push_back(tb[i]); lb_stop.push_back(1'b0);
      end
      do_run(0, 2);
      check("full_run_107", last_exp, 107);

      // Single maximal pair, then wraparound over five of them.
      load_pairs(1, 127, 127);
      do_run(0, 0);
      load_pairs(5, 127, 127);
      do_run(0, 1);

      // Stop pulses during LOAD_B must be ignored.
      load_pairs(6, -1, -1);
      lb_stop[1] = 1'b1; lb_stop[3] = 1'b1;
      do_run(0, 0);

      // Reset after three pairs, then a fresh run must not carry over.
      load_pairs(6, -1, -1);
      do_run(3, 0);
      load_pairs(4, -1, -1);
      do_run(0, 0);

      // Randomized runs.
      for (int r = 0; r < 8; r++) begin
         load_pairs(int'($urandom_range(1, 12)), -1, -1);
         for (int i = 0; i < lb_stop.size(); i++) lb_stop[i] = 1'($urandom_range(0, 1));
         do_run(0, int'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      sim_over = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
